// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared state encoding and sizing constants
// for the UART receive controller.
package uart_rx_pkg;

  localparam int DATA_W    = 8;
  localparam int BIT_CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE
  } state_e;

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// uart_rx_edge_bit_cnt: oversampling edge counter with wrap at P-1
// and data-bit index counter for the UART receive controller.
module uart_rx_edge_bit_cnt
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] wrap,
  input  logic                  bit_adv,
  input  logic                  bit_clr,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  last_edge
);

  logic [PRESCALE_W-1:0] edge_q, edge_d;
  logic [BIT_CNT_W-1:0]  bit_q, bit_d;

  assign last_edge = (edge_q == wrap);
  assign edge_cnt  = edge_q;
  assign bit_cnt   = bit_q;

  // Edge count runs while enabled, wrapping at P-1; bit index
  // advances once per data bit and clears outside the data phase.
  always_comb begin
    edge_d = '0;
    if (en && !last_edge) begin
      edge_d = edge_q + PRESCALE_W'(1);
    end
    bit_d = bit_q;
    if (bit_clr) begin
      bit_d = '0;
    end else if (bit_adv) begin
      bit_d = bit_q + BIT_CNT_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_q <= '0;
      bit_q  <= '0;
    end else begin
      edge_q <= edge_d;
      bit_q  <= bit_d;
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: UART receive sequencer (start/data/parity/stop/done).
// Parity support is built only when UART_RX_PARITY_EN is defined.
module uart_rx_fsm #(
  parameter int PRESCALE_W = 6,
  parameter int DATA_W     = uart_rx_pkg::DATA_W
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             rx_in,
  input  logic [PRESCALE_W-1:0]            prescale,
  input  logic                             par_en,
  input  logic                             strt_glitch,
  input  logic                             par_err,
  input  logic                             stop_err,
  output logic                             data_samp_en,
  output logic [PRESCALE_W-1:0]            edge_cnt,
  output logic [uart_rx_pkg::BIT_CNT_W-1:0] bit_cnt,
  output logic                             strt_chk_en,
  output logic                             deser_en,
  output logic                             par_chk_en,
  output logic                             stop_chk_en,
  output logic                             data_valid,
  output logic                             frame_err
);

  import uart_rx_pkg::*;

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);

  state_e                state_q, state_d;
  logic [PRESCALE_W-1:0] p_q, p_d;
  logic                  serr_q, serr_d;
  logic                  perr_v;
`ifdef UART_RX_PARITY_EN
  logic                  perr_q, perr_d;
  logic                  par_en_q, par_en_d;
  logic                  par_chk_en_q, par_chk_en_d;
`else
  logic                  unused_par;
  assign unused_par = par_en ^ par_err;
`endif

  logic data_samp_en_q, data_samp_en_d;
  logic strt_chk_en_q, strt_chk_en_d;
  logic deser_en_q, deser_en_d;
  logic stop_chk_en_q, stop_chk_en_d;
  logic data_valid_q, data_valid_d;
  logic frame_err_q, frame_err_d;

  logic cnt_en, bit_adv, bit_clr, last_edge, at_pre, done_nxt;

  uart_rx_edge_bit_cnt #(
    .PRESCALE_W(PRESCALE_W)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (cnt_en),
    .wrap     (p_q - PRESCALE_W'(1)),
    .bit_adv  (bit_adv),
    .bit_clr  (bit_clr),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt),
    .last_edge(last_edge)
  );

  // Next-state, flag and registered-output decode. Strobes are set
  // one edge early so they sit on edge P-1, where the FSM decides.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    serr_d  = serr_q;
    cnt_en  = 1'b0;
    bit_adv = 1'b0;
    bit_clr = 1'b1;
`ifdef UART_RX_PARITY_EN
    perr_d   = perr_q;
    par_en_d = par_en_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) begin
          serr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
          perr_d  = 1'b0;
`endif
          state_d = IDLE;
        end
        if (!rx_in) begin
          state_d  = START;
          p_d      = prescale;
          cnt_en   = 1'b1;
`ifdef UART_RX_PARITY_EN
          par_en_d = par_en;
`endif
        end
      end
      START: begin
        cnt_en = 1'b1;
        if (last_edge) begin
          state_d = strt_glitch ? IDLE : DATA;
        end
      end
      DATA: begin
        cnt_en  = 1'b1;
        bit_clr = 1'b0;
        if (last_edge) begin
          if (bit_cnt == LAST_BIT) begin
            bit_clr = 1'b1;
`ifdef UART_RX_PARITY_EN
            state_d = par_en_q ? PARITY : STOP;
`else
            state_d = STOP;
`endif
          end else begin
            bit_adv = 1'b1;
          end
        end
      end
      PARITY: begin
`ifdef UART_RX_PARITY_EN
        cnt_en = 1'b1;
        if (last_edge) begin
          perr_d  = par_err;
          state_d = STOP;
        end
`else
        state_d = IDLE;
`endif
      end
      STOP: begin
        cnt_en = 1'b1;
        if (last_edge) begin
          serr_d  = stop_err;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef UART_RX_PARITY_EN
    perr_v = perr_d;
`else
    perr_v = 1'b0;
`endif
    at_pre         = (edge_cnt == p_q - PRESCALE_W'(2));
    strt_chk_en_d  = (state_q == START) && at_pre;
    deser_en_d     = (state_q == DATA) && at_pre;
    stop_chk_en_d  = (state_q == STOP) && at_pre;
`ifdef UART_RX_PARITY_EN
    par_chk_en_d   = (state_q == PARITY) && at_pre;
`endif
    data_samp_en_d = (state_d == START) || (state_d == DATA) ||
                     (state_d == PARITY) || (state_d == STOP);
    done_nxt       = (state_d == DONE);
    data_valid_d   = done_nxt && !perr_v && !serr_d;
    frame_err_d    = done_nxt && (perr_v || serr_d);
  end

  // State, latched frame settings, error flags and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      p_q            <= '0;
      serr_q         <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q         <= 1'b0;
      par_en_q       <= 1'b0;
      par_chk_en_q   <= 1'b0;
`endif
      data_samp_en_q <= 1'b0;
      strt_chk_en_q  <= 1'b0;
      deser_en_q     <= 1'b0;
      stop_chk_en_q  <= 1'b0;
      data_valid_q   <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      p_q            <= p_d;
      serr_q         <= serr_d;
`ifdef UART_RX_PARITY_EN
      perr_q         <= perr_d;
      par_en_q       <= par_en_d;
      par_chk_en_q   <= par_chk_en_d;
`endif
      data_samp_en_q <= data_samp_en_d;
      strt_chk_en_q  <= strt_chk_en_d;
      deser_en_q     <= deser_en_d;
      stop_chk_en_q  <= stop_chk_en_d;
      data_valid_q   <= data_valid_d;
      frame_err_q    <= frame_err_d;
    end
  end

  assign data_samp_en = data_samp_en_q;
  assign strt_chk_en  = strt_chk_en_q;
  assign deser_en     = deser_en_q;
  assign stop_chk_en  = stop_chk_en_q;
  assign data_valid   = data_valid_q;
  assign frame_err    = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign par_chk_en   = par_chk_en_q;
`else
  assign par_chk_en   = 1'b0;
`endif

endmodule
